// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vend_pkg
// Description : Shared types and constants for the vending sequencing
//               controller: FSM state encoding, coin values and credit width.
// Revision    : 1.0 - initial release
// ============================================================================
package vend_pkg;

    // Credit is tracked in half-unit steps; 4 bits covers MAX_CREDIT <= 15.
    localparam int CREDIT_W = 4;

    localparam logic [CREDIT_W-1:0] HALF_VAL = 4'd1;
    localparam logic [CREDIT_W-1:0] ONE_VAL  = 4'd2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CREDIT   = 2'd1,
        ST_DISPENSE = 2'd2,
        ST_CHANGE   = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/vend_idle_timer.sv
`default_nettype none
// ============================================================================
// Module      : vend_idle_timer
// Description : Idle-cycle counter. Cleared by i_clr, counts while i_en,
//               saturates at TIMEOUT and flags o_tc while sitting there.
// Ports       : clk, reset (async, active-high), i_clr, i_en -> o_tc
// Revision    : 1.0 - initial release
// ============================================================================
module vend_idle_timer #(
    parameter int TIMEOUT = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam int              CNT_W  = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] C_TERM = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] r_cnt;

    // Saturating so a held terminal count cannot roll over to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != C_TERM)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tc = (r_cnt == C_TERM);

endmodule
`default_nettype wire

// File: rtl/vend_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vend_ctrl
// Description : Vending transaction controller. Accumulates coin credit,
//               accepts a priced selection, handshakes the dispenser and pays
//               change back one half-unit coin at a time. Cancel and an idle
//               timeout both refund the full credit through the hopper.
// Ports       : clk, reset (async, active-high)
//               half, one, sel, cancel  - single-cycle request pulses
//               disp_ack, chg_ack       - actuator acknowledges
//               disp_req, chg_req       - actuator requests (level)
//               coin_rej                - one-cycle coin-return pulse
//               credit[3:0], busy       - status
// Revision    : 1.0 - initial release
// ============================================================================
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int PRICE      = 4,
    parameter int MAX_CREDIT = 7,
    parameter int TIMEOUT    = 1000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                half,
    input  logic                one,
    input  logic                sel,
    input  logic                cancel,
    input  logic                disp_ack,
    input  logic                chg_ack,
    output logic                disp_req,
    output logic                chg_req,
    output logic                coin_rej,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    localparam logic [CREDIT_W:0]   C_MAX   = (CREDIT_W + 1)'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] C_PRICE = CREDIT_W'(PRICE);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CREDIT_W-1:0] r_credit;
    logic [CREDIT_W-1:0] w_credit_nxt;
    logic [CREDIT_W-1:0] w_credit_coin;
    logic                r_disp_req;
    logic                r_chg_req;
    logic                r_coin_rej;
    logic                r_busy;
    logic                w_coin_ok;
    logic                w_one_acc;
    logic                w_half_acc;
    logic                w_coin_acc;
    logic                w_coin_rej;
    logic                w_tc;

    // Coin evaluation. The 1.00 coin has priority; a simultaneous 0.50 coin
    // is always returned. The range check is done one bit wider so the sum
    // cannot wrap before the comparison.
    assign w_coin_ok  = (r_state == ST_IDLE) || (r_state == ST_CREDIT);
    assign w_one_acc  = one && w_coin_ok &&
                        (({1'b0, r_credit} + {1'b0, ONE_VAL}) <= C_MAX);
    assign w_half_acc = half && !one && w_coin_ok &&
                        (({1'b0, r_credit} + {1'b0, HALF_VAL}) <= C_MAX);
    assign w_coin_acc = w_one_acc || w_half_acc;
    assign w_coin_rej = (one && !w_one_acc) || (half && !w_half_acc);

    assign w_credit_coin = w_one_acc  ? (r_credit + ONE_VAL)  :
                           w_half_acc ? (r_credit + HALF_VAL) : r_credit;

    vend_idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .clk   (clk),
        .reset (reset),
        .i_clr (w_coin_acc || (r_state != ST_CREDIT)),
        .i_en  (r_state == ST_CREDIT),
        .o_tc  (w_tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_credit   <= '0;
            r_disp_req <= 1'b0;
            r_chg_req  <= 1'b0;
            r_coin_rej <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_credit   <= w_credit_nxt;
            r_disp_req <= (w_state_nxt == ST_DISPENSE);
            r_chg_req  <= (w_state_nxt == ST_CHANGE);
            r_coin_rej <= w_coin_rej;
            r_busy     <= (w_state_nxt == ST_DISPENSE) || (w_state_nxt == ST_CHANGE);
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_credit_nxt = r_credit;
        case (r_state)
            ST_IDLE, ST_CREDIT: begin
                w_credit_nxt = w_credit_coin;
                if (w_coin_acc) begin
                    w_state_nxt = ST_CREDIT;
                end
                // Selection sees the credit after this cycle's coin; a coin
                // arriving from IDLE makes the selection eligible as well.
                if ((r_state == ST_CREDIT) && cancel) begin
                    w_state_nxt = ST_CHANGE;
                end else if ((w_state_nxt == ST_CREDIT) && sel &&
                             (w_credit_coin >= C_PRICE)) begin
                    w_state_nxt  = ST_DISPENSE;
                    w_credit_nxt = w_credit_coin - C_PRICE;
                end else if ((r_state == ST_CREDIT) && w_tc && !w_coin_acc) begin
                    w_state_nxt = ST_CHANGE;
                end
            end
            ST_DISPENSE: begin
                if (disp_ack) begin
                    w_state_nxt = (r_credit != '0) ? ST_CHANGE : ST_IDLE;
                end
            end
            ST_CHANGE: begin
                if (r_credit == '0) begin
                    w_state_nxt = ST_IDLE;
                end else if (chg_ack) begin
                    w_credit_nxt = r_credit - 1'b1;
                    if (r_credit == 4'd1) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_credit_nxt = '0;
            end
        endcase
    end

    assign disp_req = r_disp_req;
    assign chg_req  = r_chg_req;
    assign coin_rej = r_coin_rej;
    assign credit   = r_credit;
    assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_vend_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_vend_ctrl
// Description : Scoreboard bench for vend_ctrl (PRICE 4, MAX_CREDIT 7,
//               TIMEOUT 10). The driver pushes the hand-computed output state
//               expected after each edge; the monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vend_ctrl;

    typedef struct packed {
        logic       disp;
        logic       chg;
        logic       rej;
        logic [3:0] cr;
        logic       bsy;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       half = 1'b0;
    logic       one = 1'b0;
    logic       sel = 1'b0;
    logic       cancel = 1'b0;
    logic       disp_ack = 1'b0;
    logic       chg_ack = 1'b0;
    logic       disp_req;
    logic       chg_req;
    logic       coin_rej;
    logic [3:0] credit;
    logic       busy;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_checks = 0;
    int    n_errors = 0;

    vend_ctrl #(
        .PRICE      (4),
        .MAX_CREDIT (7),
        .TIMEOUT    (10)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .half     (half),
        .one      (one),
        .sel      (sel),
        .cancel   (cancel),
        .disp_ack (disp_ack),
        .chg_ack  (chg_ack),
        .disp_req (disp_req),
        .chg_req  (chg_req),
        .coin_rej (coin_rej),
        .credit   (credit),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input string fld, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s %s: got %0d expected %0d", nm, fld, got, exp);
        end
    endtask

    // Monitor: outputs settle on a clock edge or on asynchronous reset.
    always @(posedge clk or posedge reset) begin
        #1;
        if (exp_q.size() != 0) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            chk(nm, "disp_req", int'(disp_req), int'(e.disp));
            chk(nm, "chg_req",  int'(chg_req),  int'(e.chg));
            chk(nm, "coin_rej", int'(coin_rej), int'(e.rej));
            chk(nm, "credit",   int'(credit),   int'(e.cr));
            chk(nm, "busy",     int'(busy),     int'(e.bsy));
        end
    end

    // One cycle: drive inputs at the falling edge, expect the given state
    // after the following rising edge.
    task automatic cyc(input string nm,
                       input logic h, input logic o, input logic s, input logic c,
                       input logic da, input logic ca,
                       input logic e_disp, input logic e_chg, input logic e_rej,
                       input int e_cr, input logic e_bsy);
        exp_t e;
        @(negedge clk);
        half = h; one = o; sel = s; cancel = c; disp_ack = da; chg_ack = ca;
        e.disp = e_disp; e.chg = e_chg; e.rej = e_rej; e.cr = 4'(e_cr); e.bsy = e_bsy;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    initial begin
        // Reset held: everything zero
        cyc("reset0", 0,0,0,0,0,0, 0,0,0,0,0);
        cyc("reset1", 0,0,0,0,0,0, 0,0,0,0,0);
        @(negedge clk);
        reset = 1'b0;

        // one, one, sel, ack after 3 cycles of disp_req
        cyc("t1_one1",  0,1,0,0,0,0, 0,0,0,2,0);
        cyc("t1_one2",  0,1,0,0,0,0, 0,0,0,4,0);
        cyc("t1_sel",   0,0,1,0,0,0, 1,0,0,0,1);
        cyc("t1_wait1", 0,0,0,0,0,0, 1,0,0,0,1);
        cyc("t1_wait2", 0,0,0,0,0,0, 1,0,0,0,1);
        cyc("t1_ack",   0,0,0,0,1,0, 0,0,0,0,0);
        cyc("t1_idle",  0,0,0,0,0,0, 0,0,0,0,0);

        // one, one, half, sel -> change of 1
        cyc("t2_one1",  0,1,0,0,0,0, 0,0,0,2,0);
        cyc("t2_one2",  0,1,0,0,0,0, 0,0,0,4,0);
        cyc("t2_half",  1,0,0,0,0,0, 0,0,0,5,0);
        cyc("t2_sel",   0,0,1,0,0,0, 1,0,0,1,1);
        cyc("t2_dack",  0,0,0,0,1,0, 0,1,0,1,1);
        cyc("t2_hold",  0,0,0,0,0,0, 0,1,0,1,1);
        cyc("t2_cack",  0,0,0,0,0,1, 0,0,0,0,0);

        // Over-limit coin rejected, then a fitting half reaches the ceiling
        cyc("t3_one1",  0,1,0,0,0,0, 0,0,0,2,0);
        cyc("t3_one2",  0,1,0,0,0,0, 0,0,0,4,0);
        cyc("t3_one3",  0,1,0,0,0,0, 0,0,0,6,0);
        cyc("t3_rej",   0,1,0,0,0,0, 0,0,1,6,0);
        cyc("t3_pulse", 0,0,0,0,0,0, 0,0,0,6,0);
        cyc("t3_half",  1,0,0,0,0,0, 0,0,0,7,0);
        cyc("t3_cancel",0,0,0,1,0,0, 0,1,0,7,1);
        for (int k = 6; k >= 0; k--) begin
            cyc("t3_refund", 0,0,0,0,0,1, 0,(k>0),0,k,(k>0));
        end

        // half and one together from IDLE
        cyc("t4_both",  1,1,0,0,0,0, 0,0,1,2,0);
        // Timeout from credit 3: ten idle cycles hold, the eleventh refunds
        cyc("t5_half",  1,0,0,0,0,0, 0,0,0,3,0);
        for (int k = 0; k < 10; k++) begin
            cyc("t5_idle", 0,0,0,0,0,0, 0,0,0,3,0);
        end
        cyc("t5_tmo",   0,0,0,0,0,0, 0,1,0,3,1);
        cyc("t5_coin",  1,0,0,0,0,0, 0,1,1,3,1);
        cyc("t5_ack1",  0,0,0,0,0,1, 0,1,0,2,1);
        cyc("t5_ack2",  0,0,0,0,0,1, 0,1,0,1,1);
        cyc("t5_ack3",  0,0,0,0,0,1, 0,0,0,0,0);

        // sel with insufficient credit ignored
        cyc("t7_half",  1,0,0,0,0,0, 0,0,0,1,0);
        cyc("t7_sel",   0,0,1,0,0,0, 0,0,0,1,0);
        cyc("t7_cancel",0,0,0,1,0,0, 0,1,0,1,1);
        cyc("t7_cack",  0,0,0,0,0,1, 0,0,0,0,0);

        // Coin and sel in one cycle: sel sees the updated credit
        cyc("t8_one",   0,1,0,0,0,0, 0,0,0,2,0);
        cyc("t8_half",  1,0,0,0,0,0, 0,0,0,3,0);
        cyc("t8_onesel",0,1,1,0,0,0, 1,0,0,1,1);
        cyc("t8_dack",  0,0,0,0,1,0, 0,1,0,1,1);
        cyc("t8_cack",  0,0,0,0,0,1, 0,0,0,0,0);

        // sel and cancel together: cancel wins
        cyc("t9_one1",  0,1,0,0,0,0, 0,0,0,2,0);
        cyc("t9_one2",  0,1,0,0,0,0, 0,0,0,4,0);
        cyc("t9_selcan",0,0,1,1,0,0, 0,1,0,4,1);
        for (int k = 3; k >= 0; k--) begin
            cyc("t9_refund", 0,0,0,0,0,1, 0,(k>0),0,k,(k>0));
        end

        // Reset in the middle of DISPENSE
        cyc("t6_one1",  0,1,0,0,0,0, 0,0,0,2,0);
        cyc("t6_one2",  0,1,0,0,0,0, 0,0,0,4,0);
        cyc("t6_sel",   0,0,1,0,0,0, 1,0,0,0,1);
        cyc("t6_disp",  0,0,0,0,0,0, 1,0,0,0,1);
        @(negedge clk);
        begin
            exp_t z;
            z = '0;
            exp_q.push_back(z); name_q.push_back("t6_async_rst");
            exp_q.push_back(z); name_q.push_back("t6_rst_hold");
            reset = 1'b1;
        end
        @(negedge clk);
        reset = 1'b0;
        cyc("t6_after", 0,0,0,0,0,0, 0,0,0,0,0);
        cyc("t6_coin",  1,0,0,0,0,0, 0,0,0,1,0);

        @(negedge clk);
        half = 0; one = 0; sel = 0; cancel = 0; disp_ack = 0; chg_ack = 0;
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vend_ctrl.md
# vend_ctrl

Sequencing controller for the vending datapath. It accumulates coin credit in half-unit steps and accepts a product selection when credit covers the price. It then handshakes with the dispenser and pays back any remaining credit one half-unit coin at a time through the change hopper. It sits between the coin acceptor / select buttons and the dispenser and hopper actuators, replacing the fixed-price state chain with a priced, cancellable, time-limited transaction.

## Interface
- PRICE, default 4: product price in half-units (4 = 2.00); 1..MAX_CREDIT.
- MAX_CREDIT, default 7: credit ceiling in half-units; ≤ 15.
- TIMEOUT, default 1000: idle cycles in CREDIT before automatic refund; ≥ 2.
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- half  in  1  single-cycle pulse, 0.50 coin inserted (synchronous to clk).
- one  in  1  single-cycle pulse, 1.00 coin inserted.
- sel  in  1  single-cycle pulse, product select.
- cancel  in  1  single-cycle pulse, abort and refund.
- disp_ack  in  1  dispenser done; sampled only while disp_req = 1.
- chg_ack  in  1  hopper ejected one half-unit coin; sampled only while chg_req = 1.
- disp_req  out  1  dispense request, level.
- chg_req  out  1  change request, level.
- coin_rej  out  1  one-cycle pulse, coin routed to return chute.
- credit  out  4  current credit in half-units.
- busy  out  1  high in DISPENSE or CHANGE.

## Operation
- States: IDLE (credit 0), CREDIT, DISPENSE, CHANGE. Reset: state IDLE; every output 0.
- Coin values: half = 1, one = 2. An accepted coin adds its value to credit; IDLE/CREDIT go to CREDIT.
- A coin is rejected (coin_rej pulse, credit unchanged) if credit + value > MAX_CREDIT, or if state is DISPENSE/CHANGE.
- half and one together: one is evaluated first. half is always rejected that cycle.
- sel in CREDIT with credit ≥ PRICE: credit −= PRICE, go DISPENSE. sel with credit < PRICE, or sel in any other state: ignored.
- A coin and sel in the same cycle: the coin is evaluated first, then sel sees the updated credit.
- DISPENSE: disp_req = 1 until disp_ack is sampled 1. Next state is CHANGE if credit > 0, else IDLE.
- CHANGE: chg_req = 1 while credit > 0. Each cycle with chg_ack = 1 decrements credit by 1. At credit 0, go IDLE with chg_req = 0.
- cancel in CREDIT: go CHANGE and refund the full credit. cancel elsewhere: ignored. sel and cancel together: cancel wins.
- Idle timer: cleared on entry to CREDIT and on each accepted coin. When it reaches TIMEOUT in CREDIT, go CHANGE (same as cancel).
- Arithmetic is unsigned 4-bit. Credit never wraps; the over-limit check guarantees this.
- Reset mid-transaction: immediate return to IDLE, credit lost, requests drop asynchronously.

## Timing
- Registered outputs: all take effect in the cycle after the causing input edge.
- Coin at edge n: credit updated and coin_rej asserted at n+1; coin_rej is 1 cycle wide.
- sel at edge n: disp_req = 1 and credit reduced at n+1.
- disp_ack high at edge m: disp_req = 0 at m+1, chg_req = 1 at m+1 if change is due.
- chg_ack: one decrement per cycle; back-to-back acks are legal. chg_req falls in the cycle credit reaches 0.
- Timeout: with no coin after entering CREDIT at edge n, chg_req rises at n+TIMEOUT+1.

## Structure
- Package vend_pkg: state enum, HALF_VAL = 1, ONE_VAL = 2, credit width constant.
- Sub-module vend_idle_timer: counter with clear and enable inputs and a terminal-count output at TIMEOUT.
- vend_ctrl holds the FSM, credit register, and output registers.

## Test plan
- one, one, sel, disp_ack after 3 cycles -> credit 2, 4, 0. disp_req high 3 cycles. No chg_req. IDLE.
- one, one, half, sel, disp_ack -> credit 5, then 1. chg_req high until one chg_ack. Credit 0, IDLE.
- Credit 6, then one -> coin_rej pulse, credit stays 6. Then half -> credit 7.
- half and one in the same cycle from IDLE -> credit 2, coin_rej pulse.
- Credit 3, no activity for TIMEOUT = 10 cycles -> chg_req high. Three chg_ack -> credit 0, IDLE. Coin during CHANGE is rejected.
- Credit 4, sel, reset asserted mid-DISPENSE -> disp_req, credit, and busy all 0 immediately. IDLE after release.
